// File: rtl/gate_truth_checker_pkg.sv
// Shared definitions for the basic-gate truth-table checkers: FSM encoding,
// vector count, standard truth tables and the X-aware mismatch helper.
package gate_truth_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int GATE_VECTORS = 4;

  // Bit i is the expected output for {a,b} == i.
  localparam logic [3:0] TRUTH_OR   = 4'b1110;
  localparam logic [3:0] TRUTH_AND  = 4'b1000;
  localparam logic [3:0] TRUTH_XOR  = 4'b0110;
  localparam logic [3:0] TRUTH_NAND = 4'b0111;
  localparam logic [3:0] TRUTH_NOR  = 4'b0001;

  // Case-inequality so that an X/Z on the gate output is never taken as a match.
  function automatic logic vec_miss(input logic y, input logic expected);
    return (y !== expected);
  endfunction

endpackage

// File: rtl/gate_truth_checker_if.sv
// Bundle of the checker's control/result signals and the gate-under-test pins.
interface gate_truth_checker_if;
  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] fail_count;
  logic [3:0] fail_mask;

  modport master (
    output start, y,
    input  a, b, busy, done, pass, fail_count, fail_mask
  );

  modport slave (
    input  start, y,
    output a, b, busy, done, pass, fail_count, fail_mask
  );
endinterface

// File: rtl/gate_truth_checker_settle_timer.sv
// 8-bit settle counter; hit flags the cycle on which the gate output is sampled.
module settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  localparam logic [7:0] HIT_VAL = 8'(SETTLE_CYCLES - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear has priority over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == HIT_VAL);

endmodule

// File: rtl/gate_truth_checker.sv
// Clocked truth-table sequencer: walks {a,b} = 00..11, samples y after a settle
// delay and accumulates a per-vector mismatch mask and count.
module gate_truth_checker
  import gate_truth_checker_pkg::*;
#(
  parameter logic [3:0] TRUTH         = TRUTH_OR,
  parameter int         SETTLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  gate_truth_checker_if.slave bus
);

  localparam logic [1:0] LAST_IDX = 2'(GATE_VECTORS - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("gate_truth_checker: SETTLE_CYCLES must be in 1..255");
  end

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] fc_q, fc_d;
  logic [3:0] fm_q, fm_d;
  logic       hit_s;
  logic       miss_s;
  logic       timer_clear_s;
  logic       timer_en_s;

  // Counter idles at zero outside RUN and restarts after every sample edge.
  assign timer_en_s    = (state_q == ST_RUN);
  assign timer_clear_s = (state_q != ST_RUN) || hit_s;

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear_s),
    .enable (timer_en_s),
    .hit    (hit_s)
  );

  // Next-state, vector drive and compare/accumulate.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fc_d    = fc_q;
    fm_d    = fm_q;
    miss_s  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          idx_d   = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fc_d    = 3'd0;
          fm_d    = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (hit_s) begin
          miss_s      = vec_miss(bus.y, TRUTH[idx_q]);
          fm_d[idx_q] = fm_q[idx_q] | miss_s;
          fc_d        = fc_q + {2'b00, miss_s};
          if (idx_q == LAST_IDX) begin
            // pass must include this final sample, so it is taken from fm_d.
            state_d = ST_DONE;
            idx_d   = 2'd0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fm_d == 4'b0000);
          end else begin
            idx_d = idx_q + 2'd1;
            a_d   = idx_d[1];
            b_d   = idx_d[0];
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        fc_d    = 3'd0;
        fm_d    = 4'd0;
      end
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fc_q    <= 3'd0;
      fm_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fc_q    <= fc_d;
      fm_q    <= fm_d;
    end
  end

  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_count = fc_q;
  assign bus.fail_mask  = fm_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: two instances (S=4, S=1) driving a
// behavioural gate; expected results are queued at start and checked at done.
module tb_gate_truth_checker;
  import gate_truth_checker_pkg::*;

  localparam int MODE_OR  = 0;
  localparam int MODE_AND = 1;
  localparam int MODE_X2  = 2;
  localparam logic [3:0] EXP_TRUTH = 4'b1110;

  typedef struct {
    logic       pass;
    logic [2:0] cnt;
    logic [3:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   gate_mode;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  gate_truth_checker_if bus4();
  gate_truth_checker_if bus1();

  gate_truth_checker #(.TRUTH(4'b1110), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave)
  );
  gate_truth_checker #(.TRUTH(4'b1110), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  function automatic logic gate_fn(input logic a, input logic b, input int mode);
    case (mode)
      MODE_AND: return a & b;
      MODE_X2:  return (a & ~b) ? 1'bx : (a | b);
      default:  return a | b;
    endcase
  endfunction

  assign bus4.y = gate_fn(bus4.a, bus4.b, gate_mode);
  assign bus1.y = gate_fn(bus1.a, bus1.b, gate_mode);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) bus1.start = v;
    else          bus4.start = v;
  endtask

  task automatic get(input int sel, output logic a, output logic b, output logic busy,
                     output logic done, output logic pass, output logic [2:0] fc,
                     output logic [3:0] fm);
    if (sel == 1) begin
      a = bus1.a; b = bus1.b; busy = bus1.busy; done = bus1.done;
      pass = bus1.pass; fc = bus1.fail_count; fm = bus1.fail_mask;
    end else begin
      a = bus4.a; b = bus4.b; busy = bus4.busy; done = bus4.done;
      pass = bus4.pass; fc = bus4.fail_count; fm = bus4.fail_mask;
    end
  endtask

  task automatic push_expect(input int mode);
    exp_t e;
    logic g;
    e.mask = 4'b0000;
    e.cnt  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      g = gate_fn(i[1], i[0], mode);
      if (g !== EXP_TRUTH[i]) begin
        e.mask[i] = 1'b1;
        e.cnt     = e.cnt + 3'd1;
      end
    end
    e.pass = (e.mask == 4'b0000);
    sb.push_back(e);
  endtask

  // Called on a negedge; raises start, then follows the run to done.
  task automatic do_run(input int sel, input int s, input int mode, input int repulse);
    logic a, b, busy, done, pass;
    logic [2:0] fc;
    logic [3:0] fm;
    int   k;
    bit   done_seen;
    exp_t e;
    gate_mode = mode;
    push_expect(mode);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    k = 0;
    done_seen = 1'b0;
    get(sel, a, b, busy, done, pass, fc, fm);
    chk("start_busy", 8'(busy), 8'd1);
    chk("start_done", 8'(done), 8'd0);
    chk("start_mask", 8'(fm), 8'd0);
    chk("start_cnt",  8'(fc), 8'd0);
    while (k <= 4 * s + 4 && !done_seen) begin
      get(sel, a, b, busy, done, pass, fc, fm);
      if (done) begin
        done_seen = 1'b1;
        chk("done_cycle", 8'(k), 8'(4 * s));
        chk("done_ab", {6'd0, a, b}, 8'd0);
        chk("done_busy", 8'(busy), 8'd0);
        chk("sb_size", 8'(sb.size()), 8'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pass", 8'(pass), 8'(e.pass));
          chk("fail_count", 8'(fc), 8'(e.cnt));
          chk("fail_mask", 8'(fm), 8'(e.mask));
        end
      end else begin
        if (k < 4 * s && (k % s) == 0) chk("vector_ab", {6'd0, a, b}, 8'(k / s));
        if (k == repulse)     set_start(sel, 1'b1);
        if (k == repulse + 1) set_start(sel, 1'b0);
        @(negedge clk);
        k++;
      end
    end
    if (!done_seen) chk("done_timeout", 8'd0, 8'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus4.start  = 1'b0;
    bus1.start  = 1'b0;
    gate_mode   = MODE_OR;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {bus4.a, bus4.b, bus4.busy, bus4.done, bus4.pass,
                        |bus4.fail_count, |bus4.fail_mask, 1'b0}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // OR gate, default truth table; done must be a held level
    do_run(4, 4, MODE_OR, -1);
    repeat (3) @(negedge clk);
    chk("done_held", {6'd0, bus4.done, bus4.pass}, 8'd3);

    // AND gate against OR expectations
    do_run(4, 4, MODE_AND, -1);
    @(negedge clk);

    // start re-pulsed mid-run is ignored
    do_run(4, 4, MODE_OR, 5);
    @(negedge clk);

    // async reset mid-run, then a clean run
    gate_mode = MODE_OR;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {bus4.a, bus4.b, bus4.busy, bus4.done, bus4.pass,
                           |bus4.fail_count, |bus4.fail_mask, 1'b0}, 8'd0);
    chk("midrst_state", 8'(dut4.state_q), 8'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_busy", 8'(bus4.busy), 8'd0);
    @(negedge clk);
    do_run(4, 4, MODE_OR, -1);
    @(negedge clk);

    // S=1 back to back: failing run, then an OR run started right after done
    do_run(1, 1, MODE_AND, -1);
    do_run(1, 1, MODE_OR, -1);
    @(negedge clk);

    // X on vector 2
    do_run(4, 4, MODE_X2, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gate_truth_checker.md
# gate_truth_checker

Self-checking truth-table sequencer for 2-input basic gates. It drives the `a`/`b` inputs of a gate instance (upstream stage) and consumes its `y` output (downstream stage). It walks all four input vectors, waits a programmable settle time, and compares `y` against a parameterised expected truth table. It reports pass/fail and a per-vector mismatch mask, replacing hand-written `#100`/`$display` benches with a synthesizable, clocked checker.

## Interface
- `TRUTH`, default `4'b1110`: expected output; bit `i` = expected `y` for `{a,b} == i`. The default is OR.
- `SETTLE_CYCLES`, default `4`: clock cycles between applying a vector and sampling `y`; legal range 1..255.
- `clk  input  1`: single clock; all logic on rising edge.
- `rst_n  input  1`: reset, asynchronous and active-low.
- `start  input  1`: begin a run; sampled only when not busy.
- `y  input  1`: gate output under test; same clock domain, no synchroniser.
- `a  output  1`: gate input A, registered.
- `b  output  1`: gate input B, registered.
- `busy  output  1`: run in progress.
- `done  output  1`: run complete; held until next accepted `start` or reset.
- `pass  output  1`: valid when `done`; 1 iff `fail_mask == 0`.
- `fail_count  output  3`: number of mismatching vectors, 0..4.
- `fail_mask  output  4`: bit `i` set if vector `i` mismatched.

## Operation
- **Reset values.** All outputs are 0 while `rst_n` is low: `a`, `b`, `busy`, `done`, `pass`, `fail_count`, `fail_mask`. The FSM is in IDLE, the vector index is 0 and the settle counter is 0.
- **States.**
  - IDLE: waits for `start`.
  - RUN: a vector is applied and the settle counter is running.
  - DONE: results held.
- **IDLE/DONE → RUN.** Happens on `start=1`. At that edge:
  - `busy` goes to 1 and `done`/`pass` go to 0.
  - `fail_count` and `fail_mask` are cleared.
  - The vector index and counter are set to 0, so `a`/`b` = 0/0.
- **Vector mapping.** `a` = idx[1], `b` = idx[0]. Vectors are applied in the order 00, 01, 10, 11.
- **RUN, counter below `SETTLE_CYCLES-1`.** The counter increments.
- **RUN, counter equal to `SETTLE_CYCLES-1`.** This is the sample edge:
  - `y` is compared with `TRUTH[idx]`.
  - On mismatch, `fail_mask[idx]` is set and `fail_count` increments.
  - A `y` of X/Z counts as a mismatch; use case-inequality in the comparison.
  - The counter resets to 0.
  - If idx < 3: idx increments and the next vector is driven at this same edge.
  - If idx == 3: go to DONE, `busy`=0, `done`=1, `a`/`b` return to 0/0. `pass` reflects the final mask, including this last sample.
- **`start` while busy.** Ignored; no restart and no effect on results.
- **`start` in DONE.** Starts a new run, same as from IDLE.
- **Async reset mid-run.** All state and outputs clear immediately. No partial result is retained.
- **`fail_count` width.** The counter cannot overflow (maximum 4).
- **Illegal parameter.** `SETTLE_CYCLES == 0` is illegal; trigger a simulation `$error` at elaboration.

## Timing
- Start is accepted at edge E0.
- Vector `i` is applied at edge E0 + i·S and sampled at edge E0 + (i+1)·S, where S = `SETTLE_CYCLES`.
- `done` rises after edge E0 + 4·S; `busy` falls at the same edge.
- The gate path must settle within S−1 cycles plus combinational delay. With S=1, `y` is sampled one edge after the vector is driven.
- `done` is a level, not a pulse.
- A new `start` can be accepted in the cycle immediately after `done` rises.

## Structure
- Shared header `gate_check_defs.vh`:
  - FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Localparam `GATE_VECTORS = 4`.
  - Standard `TRUTH` constants for OR, AND, XOR, NAND and NOR, for reuse by the other basic-gate checkers.
- One natural sub-module: `settle_timer`, an 8-bit counter with `clear`/`enable` inputs and a `hit` output at `SETTLE_CYCLES-1`.
- Compare/accumulate logic and the FSM stay in the top level.

## Test plan
- **OR gate, default `TRUTH`, S=4.** Pulse `start`. Required: `done` 16 cycles later, `pass=1`, `fail_count=0`, `fail_mask=4'b0000`, `a`/`b` sequence 00, 01, 10, 11, then 00.
- **AND gate wired in, `TRUTH=4'b1110`.** Required: `pass=0`, `fail_mask=4'b0110`, `fail_count=2`.
- **`start` re-pulsed at cycle 5 of a run.** Required: results and `done` timing identical to an undisturbed run, i.e. `done` after 16 cycles from the first start.
- **`rst_n` low at cycle 9, high at cycle 11.** Required: all outputs 0 immediately and FSM in IDLE. A fresh `start` then completes normally with `pass=1`.
- **S=1, OR gate, two back-to-back runs.** Start the second run in the cycle after `done`. Required: each run completes 4 cycles after its start, and `fail_mask` is cleared at the second start.
- **`y` forced to X on vector 2.** Required: `fail_mask=4'b0100`, `fail_count=1`, `pass=0`.
